regfile_sequencer: RTL and testbench



---
 rtl/regfile_sequencer_pkg.sv | 23 ++
 rtl/regfile_sequencer.sv | 140 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_pkg.sv
// Shared types for the register-file sequencer: command opcodes, FSM states
// and default widths.
package regfile_seq_pkg;

   localparam int DATA_WIDTH_DEF  = 16;
   localparam int INDEX_WIDTH_DEF = 2;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_ADD   = 2'd2,
      OP_COPY  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      RD1  = 3'd2,
      WB   = 3'd3,
      RESP = 3'd4
   } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Initiator-side driver for a small register file: takes one command at a time
// and sequences WRITE / READ / ADD / COPY accesses through a five-state FSM.
module regfile_sequencer
   import regfile_seq_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [INDEX_WIDTH-1:0] cmd_rd,
   input  logic [INDEX_WIDTH-1:0] cmd_rs,
   input  logic [DATA_WIDTH-1:0]  cmd_data,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [DATA_WIDTH-1:0]  resp_data,
   output logic                   busy,
   output logic [INDEX_WIDTH-1:0] rf_read_index_a,
   input  logic [DATA_WIDTH-1:0]  rf_read_data_a,
   output logic [INDEX_WIDTH-1:0] rf_write_index,
   output logic [DATA_WIDTH-1:0]  rf_write_data,
   output logic                   rf_write_enable
);

   state_e                 state_q, state_d;
   op_e                    op_q, op_d;
   logic [INDEX_WIDTH-1:0] rd_q, rd_d;
   logic [INDEX_WIDTH-1:0] rs_q, rs_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic [DATA_WIDTH-1:0]  sampled_q, sampled_d;

   logic [INDEX_WIDTH-1:0] rd_idx_q, rd_idx_d;
   logic                   we_q, we_d;
   logic [INDEX_WIDTH-1:0] widx_q, widx_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic                   resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
   logic                   busy_q, busy_d;

   logic                   accept;
   logic [INDEX_WIDTH-1:0] src_idx;

   assign cmd_ready = (state_q == IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      rs_d      = rs_q;
      data_d    = data_q;
      sampled_d = sampled_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = op_e'(cmd_op);
               rd_d    = cmd_rd;
               rs_d    = cmd_rs;
               data_d  = cmd_data;
               state_d = (op_e'(cmd_op) == OP_WRITE) ? WB : RD0;
            end
         end
         RD0:  state_d = RD1;
         // RD0 only gives a registered-read register file time to respond;
         // the value is always taken at the end of RD1.
         RD1: begin
            sampled_d = rf_read_data_a;
            state_d   = (op_q == OP_READ) ? RESP : WB;
         end
         WB:   state_d = IDLE;
         RESP: if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next-state values.
      src_idx  = (op_d == OP_COPY) ? rs_d : rd_d;
      rd_idx_d = ((state_d == RD0) || (state_d == RD1)) ? src_idx : '0;

      we_d    = (state_d == WB);
      widx_d  = we_d ? rd_d : '0;
      wdata_d = '0;
      if (we_d) begin
         case (op_d)
            OP_WRITE: wdata_d = data_d;
            OP_ADD:   wdata_d = sampled_d + data_d;
            OP_COPY:  wdata_d = sampled_d;
            default:  wdata_d = '0;
         endcase
      end

      resp_valid_d = (state_d == RESP);
      resp_data_d  = resp_valid_d ? sampled_d : '0;
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         op_q         <= OP_WRITE;
         rd_q         <= '0;
         rs_q         <= '0;
         data_q       <= '0;
         sampled_q    <= '0;
         rd_idx_q     <= '0;
         we_q         <= 1'b0;
         widx_q       <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         rd_q         <= rd_d;
         rs_q         <= rs_d;
         data_q       <= data_d;
         sampled_q    <= sampled_d;
         rd_idx_q     <= rd_idx_d;
         we_q         <= we_d;
         widx_q       <= widx_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         busy_q       <= busy_d;
      end
   end

   assign rf_read_index_a = rd_idx_q;
   assign rf_write_enable = we_q;
   assign rf_write_index  = widx_q;
   assign rf_write_data   = wdata_q;
   assign resp_valid      = resp_valid_q;
   assign resp_data       = resp_data_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a 4x16 register file beside the DUT, directed
// scenarios, then random commands against an array-based model.
module tb_regfile_sequencer;

   localparam int DW = 16;
   localparam int IW = 2;
   localparam logic [1:0] WR = 2'd0, RD = 2'd1, AD = 2'd2, CP = 2'd3;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [IW-1:0] cmd_rd;
   logic [IW-1:0] cmd_rs;
   logic [DW-1:0] cmd_data;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_data;
   logic          busy;
   logic [IW-1:0] rf_read_index_a;
   logic [DW-1:0] rf_read_data_a;
   logic [IW-1:0] rf_write_index;
   logic [DW-1:0] rf_write_data;
   logic          rf_write_enable;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] model [4];
   logic [DW-1:0] rf_mem [4];
   logic          watch_we = 1'b0;
   logic          we_seen  = 1'b0;

   always #5 clk = ~clk;

   regfile_sequencer #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
      .clk             (clk),
      .reset           (reset),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_rd          (cmd_rd),
      .cmd_rs          (cmd_rs),
      .cmd_data        (cmd_data),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_data       (resp_data),
      .busy            (busy),
      .rf_read_index_a (rf_read_index_a),
      .rf_read_data_a  (rf_read_data_a),
      .rf_write_index  (rf_write_index),
      .rf_write_data   (rf_write_data),
      .rf_write_enable (rf_write_enable)
   );

   // Register file: synchronous write, combinational read, cleared by reset.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
      end else if (rf_write_enable) begin
         rf_mem[rf_write_index] <= rf_write_data;
      end
   end
   assign rf_read_data_a = rf_mem[rf_read_index_a];

   always @(negedge clk) begin
      if (watch_we && rf_write_enable === 1'b1) we_seen = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one command (called and returning at a negedge) and checks its
   // acceptance, latency and, for READ, the response against the model.
   task automatic run_cmd(input logic [1:0] op, input logic [IW-1:0] rd, input logic [IW-1:0] rs,
                          input logic [DW-1:0] data, input int hold, input string tag);
      int            guard;
      int            idx;
      logic [DW-1:0] exp_r;
      logic [DW-1:0] held;
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_rd     = rd;
      cmd_rs     = rs;
      cmd_data   = data;
      resp_ready = 1'b0;
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      exp_r = model[rd];
      case (op)
         WR: model[rd] = data;
         AD: model[rd] = model[rd] + data;
         CP: model[rd] = model[rs];
         default: ;
      endcase
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = 16'($urandom);
      idx = 1;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (op == RD) begin
         while (resp_valid !== 1'b1 && idx < 10) begin
            @(negedge clk);
            idx++;
         end
         check({tag, "_resp_lat"}, 32'(idx), 32'd3);
         check({tag, "_resp_data"}, 32'(resp_data), 32'(exp_r));
         held = resp_data;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(resp_data), 32'(held));
            check({tag, "_hold_ready"}, 32'(cmd_ready), 32'd0);
         end
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
         check({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
         check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
      end else begin
         while (cmd_ready !== 1'b1 && idx < 10) begin
            @(negedge clk);
            idx++;
         end
         check({tag, "_lat"}, 32'(idx), (op == WR) ? 32'd2 : 32'd4);
      end
   endtask

   initial begin
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_rd     = '0;
      cmd_rs     = '0;
      cmd_data   = '0;
      resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready_low", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_we", 32'(rf_write_enable), 32'd0);
      check("rst_widx", 32'(rf_write_index), 32'd0);
      check("rst_ridx", 32'(rf_read_index_a), 32'd0);

      run_cmd(WR, 2'd0, 2'd3, 16'h0003, 0, "wr0");
      run_cmd(RD, 2'd0, 2'd2, 16'h1234, 0, "rd0");

      run_cmd(WR, 2'd1, 2'd0, 16'hFFFF, 0, "wr1");
      run_cmd(AD, 2'd1, 2'd2, 16'h0001, 0, "add1");
      run_cmd(RD, 2'd1, 2'd0, 16'h0000, 0, "rd1_wrap");
      check("wrap_model", 32'(model[1]), 32'h0000);

      run_cmd(WR, 2'd2, 2'd1, 16'h0007, 0, "wr2");
      run_cmd(CP, 2'd3, 2'd2, 16'hABCD, 0, "cp32");
      run_cmd(RD, 2'd3, 2'd1, 16'h0000, 0, "rd3");
      run_cmd(RD, 2'd2, 2'd0, 16'h0000, 0, "rd2_src");

      run_cmd(RD, 2'd0, 2'd1, 16'h0000, 5, "rd0_hold");

      // ADD aborted by reset while in RD1: no write may reach the register file.
      we_seen   = 1'b0;
      watch_we  = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = AD;
      cmd_rd    = 2'd0;
      cmd_data  = 16'h0005;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("abort_busy_rd1", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_ready_in_rst", 32'(cmd_ready), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;
      @(negedge clk);
      watch_we = 1'b0;
      check("abort_no_write", 32'(we_seen), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd1);
      run_cmd(RD, 2'd0, 2'd0, 16'h0000, 0, "abort_rd0");

      for (int n = 0; n < 60; n++) begin
         run_cmd(2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom),
                 int'($urandom_range(0, 3)), "rnd");
      end

      for (int i = 0; i < 4; i++) begin
         run_cmd(RD, 2'(i), 2'd0, 16'h0000, 0, "final_rd");
         check("final_mem", 32'(rf_mem[i]), 32'(model[i]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
